// File: rtl/gray_code_engine.sv
// gray_code_engine: registered Gray/binary converter, Gray sequence generator and Gray sequence checker.
module gray_code_engine #(
  parameter int WIDTH = 4,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [1:0]           mode,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_err,
  output logic [ERR_CNT_W-1:0] err_count,
  input  logic                 clr_err
);
  logic accept, is_chk, err, hist_valid;
  logic [WIDTH-1:0] g2b, cnt, prev, diff;
  logic [ERR_CNT_W-1:0] err_base;
  assign in_ready = !out_valid || out_ready;
  assign accept = in_valid && in_ready;
  assign is_chk = mode == 2'b11;
  assign diff = in_data ^ prev;
  // a legal Gray step differs from the previous code in exactly one bit
  assign err = is_chk && hist_valid && !(diff != '0 && (diff & (diff - WIDTH'(1))) == '0);
  assign err_base = clr_err ? '0 : err_count;
  always_comb begin
    g2b = '0;
    for (int i = 0; i < WIDTH; i++) g2b[i] = ^(in_data >> i);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_err    <= 1'b0;
      err_count  <= '0;
      cnt        <= '0;
      prev       <= '0;
      hist_valid <= 1'b0;
    end else begin
      err_count <= (accept && err && ~&err_base) ? err_base + ERR_CNT_W'(1) : err_base;
      if (accept) begin
        out_valid  <= 1'b1;
        out_data   <= mode == 2'b01 ? in_data ^ (in_data >> 1) :
                      mode == 2'b10 ? cnt ^ (cnt >> 1) : g2b;
        out_err    <= err;
        hist_valid <= is_chk;
        if (mode == 2'b10) cnt <= cnt + WIDTH'(1);
        if (is_chk) prev <= in_data;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_gray_code_engine.sv
// tb_gray_code_engine: table-driven directed checks of gray_code_engine at WIDTH=4.
module tb_gray_code_engine;
  logic clk = 0, rst_n = 0, in_valid = 0, out_ready = 1, clr_err = 0;
  logic [1:0] mode = 0;
  logic [3:0] in_data = 0;
  logic in_ready, out_valid, out_err;
  logic [3:0] out_data;
  logic [7:0] err_count;
  int checks = 0, errors = 0;

  gray_code_engine #(.WIDTH(4), .ERR_CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_err(out_err), .err_count(err_count), .clr_err(clr_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] m;
    logic [3:0] d;
    logic [3:0] q;
    logic       e;
  } vec_t;

  function automatic logic [3:0] ref_g2b(logic [3:0] g);
    logic [3:0] b;
    b[3] = g[3];
    for (int i = 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  function automatic logic [3:0] ref_b2g(logic [3:0] b);
    logic [3:0] g;
    g[3] = b[3];
    for (int i = 0; i < 3; i++) g[i] = b[i] ^ b[i+1];
    return g;
  endfunction

  task automatic chk(string n, logic [31:0] a, logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask

  // one accepted beat with out_ready=1; returns with the result visible
  task automatic beat(logic [1:0] m, logic [3:0] d, logic clr);
    @(negedge clk);
    mode = m;
    in_data = d;
    clr_err = clr;
    in_valid = 1;
    @(negedge clk);
    in_valid = 0;
    clr_err = 0;
    chk("beat_valid", out_valid, 1);
  endtask

  vec_t tbl[25];
  logic [3:0] gseq[17] = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4, 4'hC,
                           4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8, 4'h0};
  logic [3:0] t, cnt;

  initial begin
    tbl[0] = '{2'b00, 4'b1101, 4'b1001, 1'b0};
    tbl[1] = '{2'b01, 4'b1001, 4'b1101, 1'b0};
    for (int k = 0; k < 17; k++) tbl[2+k] = '{2'b10, 4'h0, gseq[k], 1'b0};
    tbl[19] = '{2'b11, 4'h0, 4'h0, 1'b0};
    tbl[20] = '{2'b11, 4'h1, 4'h1, 1'b0};
    tbl[21] = '{2'b11, 4'h3, 4'h2, 1'b0};
    tbl[22] = '{2'b11, 4'h6, 4'h4, 1'b1};
    tbl[23] = '{2'b11, 4'h6, 4'h4, 1'b1};
    tbl[24] = '{2'b11, 4'h4, 4'h7, 1'b0};

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_err", out_err, 0);
    chk("rst_err_count", err_count, 0);
    chk("rst_in_ready", in_ready, 1);
    rst_n = 1;

    for (int k = 0; k < 25; k++) begin
      beat(tbl[k].m, tbl[k].d, 0);
      chk($sformatf("tbl%0d_data", k), out_data, tbl[k].q);
      chk($sformatf("tbl%0d_err", k), out_err, tbl[k].e);
    end
    chk("chk_err_count", err_count, 2);

    beat(2'b11, 4'h4, 1);
    chk("clr_err_beat", out_err, 1);
    chk("clr_err_count", err_count, 1);
    for (int k = 0; k < 260; k++) beat(2'b11, 4'h4, 0);
    chk("sat_err_count", err_count, 255);

    for (int v = 0; v < 16; v++) begin
      beat(2'b00, 4'(v), 0);
      chk("sweep_g2b", out_data, ref_g2b(4'(v)));
      chk("sweep_g2b_err", out_err, 0);
      beat(2'b01, 4'(v), 0);
      chk("sweep_b2g", out_data, ref_b2g(4'(v)));
      t = out_data;
      beat(2'b00, t, 0);
      chk("round_trip", out_data, v);
    end

    cnt = 4'd1;
    @(negedge clk);
    mode = 2'b10;
    in_valid = 1;
    out_ready = 0;
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      chk("bp_in_ready", in_ready, 0);
      chk("bp_valid", out_valid, 1);
      chk("bp_hold", out_data, ref_b2g(cnt));
      @(negedge clk);
    end
    out_ready = 1;
    for (int k = 0; k < 5; k++) begin
      chk("bp_drain_valid", out_valid, 1);
      chk("bp_drain_data", out_data, ref_b2g(cnt));
      cnt = cnt + 1;
      if (k == 4) in_valid = 0;
      @(negedge clk);
    end
    chk("bp_drained", out_valid, 0);

    mode = 2'b10;
    in_valid = 1;
    out_ready = 0;
    @(negedge clk);
    in_valid = 0;
    chk("pre_rst_valid", out_valid, 1);
    chk("pre_rst_data", out_data, ref_b2g(cnt));
    rst_n = 0;
    @(negedge clk);
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_err_count", err_count, 0);
    rst_n = 1;
    out_ready = 1;
    beat(2'b10, 4'hF, 0);
    chk("post_rst_gen", out_data, 0);
    chk("post_rst_err", out_err, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/gray_code_engine.md
Name: gray_code_engine

Overview:
- Parametrised, registered Gray/binary code engine with valid/ready handshakes on input and output.
- Generalises the 4-bit combinational Gray-to-binary converter to any width.
- Adds binary-to-Gray conversion, a Gray sequence generator mode and a Gray-sequence checker mode with error counting.
- Sits between counter/pointer logic (e.g. async FIFO pointers, encoder interfaces) and consumers that need validated conversions.

Parameters:
- WIDTH, 4, data width in bits; legal range 2..32.
- ERR_CNT_W, 8, width of saturating error counter.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- mode  input  2  per-beat mode: 00 gray->bin, 01 bin->gray, 10 generate, 11 check
- in_valid  input  1  input beat valid
- in_ready  output  1  engine can accept a beat
- in_data  input  WIDTH  input code (ignored in mode 10)
- out_valid  output  1  output beat valid
- out_ready  input  1  consumer accepts output beat
- out_data  output  WIDTH  result code
- out_err  output  1  check-mode error flag for this beat (0 in other modes)
- err_count  output  ERR_CNT_W  saturating count of check errors
- clr_err  input  1  synchronous clear of err_count

Behaviour:
- Reset: the only clock and reset are clk and rst_n, one clock domain; reset is synchronous, active-low, sampled on the rising edge of clk.
- Values while rst_n=0 at the edge: out_valid=0, out_data=0, out_err=0, err_count=0, generator count=0, checker history invalid.
- Reset asserted mid-operation discards any held output beat; no beat is emitted for it.
- Handshake: input transfer when in_valid && in_ready; output transfer when out_valid && out_ready.
- in_ready = !out_valid || out_ready (single output register, full throughput, combinational ready path only).
- Latency: a beat accepted at edge N presents out_valid=1 with its result after edge N.
- While out_valid=1 && out_ready=0, out_data and out_err hold stable.
- mode is sampled per accepted beat; mode changes between beats are legal.
- Mode 00 (gray->bin): b[W-1]=g[W-1]; b[i]=b[i+1]^g[i].
- Mode 01 (bin->gray): g = b ^ (b>>1).
- Mode 10 (generate): in_data is ignored and in_valid acts as a request. out_data = Gray of the internal binary count. The count increments on each accepted mode-10 beat and wraps from 2^WIDTH-1 to 0. The count is retained across other modes.
- Mode 11 (check):
  - out_data = gray->bin of in_data.
  - out_err=1 if history is valid and popcount(in_data ^ prev) != 1. Identical repeats are errors.
  - If history is invalid, out_err=0.
  - prev <= in_data and history becomes valid on each accepted check beat.
  - History is invalidated when a beat with mode != 11 is accepted.
- err_count increments on each accepted check beat with error and saturates at all-ones.
- clr_err clears err_count. If clr_err coincides with an error beat, the result is 1 (clear then count).
- No combinational path from in_data to out_data.

Test Plan:
- WIDTH=4, mode 00, in_data=4'b1101 -> one cycle later out_valid=1, out_data=4'b1001. Sweep 0..15 and compare against reference model.
- Mode 01, in_data=4'b1001 -> out_data=4'b1101. Round trip 00 after 01 for all 16 values returns the original.
- Mode 10, 17 consecutive requests with out_ready=1 -> out_data 0,1,3,2,6,7,5,4,C,D,F,E,A,B,9,8,0 (wrap).
- Mode 11, inputs 0,1,3,6,6,4 -> out_err 0,0,0,1,1,0 and err_count=2.
  - Then clr_err together with an error beat -> err_count=1.
  - Then 260 error beats -> err_count=255.
- Backpressure: out_ready=0 for 5 cycles with in_valid=1.
  - in_ready=0 after the first accept, and out_data is held.
  - On release, all beats arrive in order with no loss or duplication.
- Reset mid-stream: rst_n=0 for one edge during mode 10 with out_valid=1.
  - out_valid=0 and err_count=0.
  - The next generate request yields out_data=0.
